// File: rtl/sa_ctrl.sv
// Systolic-array job controller: sequences the weight load, start/end pulses,
// X source indexing and result-row strobes for one job of N input vectors.
module sa_ctrl #(
  parameter int unsigned S     = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_JOB_VLD,
  output logic               O_JOB_RDY,
  input  logic [CNT_W-1:0]   I_JOB_LEN,
  output logic               O_W_LOAD,
  input  logic               I_W_RDY,
  output logic               O_SA_START,
  output logic               O_SA_END,
  input  logic               I_SA_SHIFT,
  output logic [CNT_W+7:0]   O_X_IDX,
  output logic               O_X_ZERO,
  output logic               O_Y_VLD,
  output logic [CNT_W-1:0]   O_Y_IDX,
  input  logic               I_ABORT,
  output logic               O_BUSY,
  output logic               O_DONE
);

  localparam int unsigned KW = CNT_W + 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_START,
    ST_RUN,
    ST_END,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] n_q;
  logic             aborted_q;

  logic [KW-1:0]    k_inc;
  logic [KW-1:0]    k_last;
  logic             row_hit;
  logic [CNT_W-1:0] y_row;

  // Shift-count arithmetic: next K, final K (S+N-1) and the result row it maps to.
  always_comb begin
    k_inc   = k_q + KW'(1);
    k_last  = KW'(S) + KW'(n_q) - KW'(1);
    row_hit = (k_inc >= KW'(S)) && (k_inc <= k_last);
    y_row   = CNT_W'(k_inc - KW'(S));
  end

  // Job FSM with registered pulse outputs, shift counter and latched job length.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      aborted_q  <= 1'b0;
      O_W_LOAD   <= 1'b0;
      O_SA_START <= 1'b0;
      O_SA_END   <= 1'b0;
      O_Y_VLD    <= 1'b0;
      O_Y_IDX    <= '0;
      O_DONE     <= 1'b0;
    end else begin
      O_W_LOAD   <= 1'b0;
      O_SA_START <= 1'b0;
      O_SA_END   <= 1'b0;
      O_Y_VLD    <= 1'b0;
      O_DONE     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (I_JOB_VLD) begin
            n_q       <= I_JOB_LEN;
            k_q       <= '0;
            aborted_q <= 1'b0;
            if (I_JOB_LEN == '0) begin
              state_q <= ST_DONE;
              O_DONE  <= 1'b1;
            end else begin
              state_q  <= ST_WLOAD;
              O_W_LOAD <= 1'b1;
            end
          end
        end
        ST_WLOAD: begin
          // Weight ready seen alongside the load request is stale; wait one more cycle.
          if (I_ABORT) begin
            state_q <= ST_IDLE;
          end else if (I_W_RDY && !O_W_LOAD) begin
            state_q    <= ST_START;
            O_SA_START <= 1'b1;
          end
        end
        ST_START: begin
          if (I_ABORT) begin
            state_q   <= ST_END;
            O_SA_END  <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (I_ABORT) begin
            state_q   <= ST_END;
            O_SA_END  <= 1'b1;
            aborted_q <= 1'b1;
          end else if (I_SA_SHIFT) begin
            k_q <= k_inc;
            if (row_hit) begin
              O_Y_VLD <= 1'b1;
              O_Y_IDX <= y_row;
            end
            if (k_inc == k_last) begin
              state_q  <= ST_END;
              O_SA_END <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (aborted_q) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
            O_DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // State decodes and X source controls derived from registered state, K and N.
  always_comb begin
    O_JOB_RDY = (state_q == ST_IDLE);
    O_BUSY    = (state_q != ST_IDLE);
    O_X_IDX   = k_q;
    O_X_ZERO  = (k_q >= KW'(n_q));
  end

endmodule
